a2bus_capture: RTL and testbench

Parametrised Apple II bus sampler: phase counter, sample points programmable at run time, missed-sample detection, and a transaction FIFO with a valid/ready read port. It runs in the logic clock domain downstream of a2bus_timing. It takes the conditioned Phi1 level and raw bus pins, and presents latched address/data/rw, strobes and queued bus transactions to card logic that may not service every cycle.

---
 rtl/a2bus_capture.sv | 179 +++++++++++++++++
 tb/tb_a2bus_capture.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/a2bus_capture.sv
`default_nettype none
// ============================================================================
// Module   : a2bus_capture
// Purpose  : Apple II bus sampler with phase counter, programmable sample
//            points, missed-sample accounting and a transaction FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module a2bus_capture #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int CNT_WIDTH   = 6,
    parameter int FIFO_DEPTH  = 4,
    parameter int SLEEP_COUNT = 63
) (
    input  logic                             clk_logic_i,
    input  logic                             system_reset_n_i,
    input  logic                             phi1_i,
    input  logic [ADDR_WIDTH-1:0]            a2_a_i,
    input  logic [DATA_WIDTH-1:0]            a2_d_i,
    input  logic                             a2_rw_n_i,
    input  logic [CNT_WIDTH-1:0]             cfg_addr_count_i,
    input  logic [CNT_WIDTH-1:0]             cfg_data_count_i,
    input  logic                             clr_i,
    output logic [ADDR_WIDTH-1:0]            addr_o,
    output logic                             rw_n_o,
    output logic [DATA_WIDTH-1:0]            data_o,
    output logic                             addr_strobe_o,
    output logic                             data_strobe_o,
    output logic                             rd_valid_o,
    input  logic                             rd_ready_i,
    output logic [ADDR_WIDTH+DATA_WIDTH:0]   rd_data_o,
    output logic                             overflow_o,
    output logic [7:0]                       miss_count_o,
    output logic                             sleep_o
);

    localparam int                     c_PTR_W    = $clog2(FIFO_DEPTH);
    localparam int                     c_ENTRY_W  = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0]   c_CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0]   c_CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]   c_SLEEP    = CNT_WIDTH'(SLEEP_COUNT);
    localparam logic [c_PTR_W-1:0]     c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_PTR_W:0]       c_LVL_ONE  = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W:0]       c_LVL_FULL = (c_PTR_W + 1)'(FIFO_DEPTH);

    logic                    r_phi1_d;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic                    r_addr_ok;
    logic                    r_data_done;
    logic [c_PTR_W-1:0]      r_wr_ptr;
    logic [c_PTR_W-1:0]      r_rd_ptr;
    logic [c_PTR_W:0]        r_level;
    logic [c_ENTRY_W-1:0]    r_mem [FIFO_DEPTH];

    logic                    w_edge;
    logic                    w_addr_hit;
    logic                    w_data_hit;
    logic                    w_miss_phi1;
    logic                    w_miss_phi0;
    logic                    w_miss;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_push_ok;
    logic                    w_drop;
    logic [c_ENTRY_W-1:0]    w_entry;

    assign w_edge      = (phi1_i != r_phi1_d);
    assign w_addr_hit  = r_phi1_d  && !w_edge && (r_cnt == cfg_addr_count_i);
    assign w_data_hit  = !r_phi1_d && !w_edge && (r_cnt == cfg_data_count_i);
    // A phase that closes without its sample point being reached is a miss.
    assign w_miss_phi1 = w_edge &&  r_phi1_d && !r_addr_ok;
    assign w_miss_phi0 = w_edge && !r_phi1_d && !r_data_done;
    assign w_miss      = w_miss_phi1 || w_miss_phi0;

    assign w_push      = w_data_hit && r_addr_ok;
    assign w_pop       = rd_valid_o && rd_ready_i;
    assign w_full      = (r_level == c_LVL_FULL);
    assign w_push_ok   = w_push && (!w_full || w_pop);
    assign w_drop      = w_push && w_full && !w_pop;
    assign w_entry     = {rw_n_o, addr_o, a2_d_i};

    assign rd_valid_o  = (r_level != '0);
    assign rd_data_o   = r_mem[r_rd_ptr];
    assign sleep_o     = (r_cnt >= c_SLEEP);

    always_ff @(posedge clk_logic_i) begin
        if (!system_reset_n_i) begin
            r_phi1_d      <= 1'b0;
            r_cnt         <= c_CNT_MAX;
            r_addr_ok     <= 1'b0;
            r_data_done   <= 1'b0;
            addr_o        <= '0;
            rw_n_o        <= 1'b1;
            data_o        <= '0;
            addr_strobe_o <= 1'b0;
            data_strobe_o <= 1'b0;
        end else begin
            r_phi1_d      <= phi1_i;
            addr_strobe_o <= w_addr_hit;
            data_strobe_o <= w_data_hit;

            if (w_edge) begin
                r_cnt <= '0;
            end else if (r_cnt != c_CNT_MAX) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end

            if (w_addr_hit) begin
                addr_o <= a2_a_i;
                rw_n_o <= a2_rw_n_i;
            end

            // Reads leave the last written data in place.
            if (w_data_hit && !rw_n_o) begin
                data_o <= a2_d_i;
            end

            if (w_addr_hit) begin
                r_addr_ok <= 1'b1;
            end else if (w_data_hit || w_miss_phi0) begin
                r_addr_ok <= 1'b0;
            end

            if (w_edge) begin
                r_data_done <= 1'b0;
            end else if (w_data_hit) begin
                r_data_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_logic_i) begin
        if (!system_reset_n_i) begin
            overflow_o   <= 1'b0;
            miss_count_o <= 8'd0;
        end else begin
            if (w_drop) begin
                overflow_o <= 1'b1;
            end else if (clr_i) begin
                overflow_o <= 1'b0;
            end

            if (clr_i) begin
                miss_count_o <= w_miss ? 8'd1 : 8'd0;
            end else if (w_miss && (miss_count_o != 8'hFF)) begin
                miss_count_o <= miss_count_o + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_logic_i) begin
        if (!system_reset_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_level <= r_level + c_LVL_ONE;
                2'b01:   r_level <= r_level - c_LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk_logic_i) begin
        if (system_reset_n_i && w_push_ok) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_a2bus_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_a2bus_capture
// Purpose  : Directed vector table plus hand sequences for a2bus_capture.
// Revision : 1.0 - initial release
// ============================================================================
module tb_a2bus_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        phi1;
    logic [15:0] a2_a;
    logic [7:0]  a2_d;
    logic        a2_rw_n;
    logic [5:0]  cfg_addr;
    logic [5:0]  cfg_data;
    logic        clr;
    logic [15:0] addr;
    logic        rw_n;
    logic [7:0]  data;
    logic        addr_strobe;
    logic        data_strobe;
    logic        rd_valid;
    logic        rd_ready;
    logic [24:0] rd_data;
    logic        overflow;
    logic [7:0]  miss_count;
    logic        sleep;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    a2bus_capture dut (
        .clk_logic_i      (clk),
        .system_reset_n_i (rst_n),
        .phi1_i           (phi1),
        .a2_a_i           (a2_a),
        .a2_d_i           (a2_d),
        .a2_rw_n_i        (a2_rw_n),
        .cfg_addr_count_i (cfg_addr),
        .cfg_data_count_i (cfg_data),
        .clr_i            (clr),
        .addr_o           (addr),
        .rw_n_o           (rw_n),
        .data_o           (data),
        .addr_strobe_o    (addr_strobe),
        .data_strobe_o    (data_strobe),
        .rd_valid_o       (rd_valid),
        .rd_ready_i       (rd_ready),
        .rd_data_o        (rd_data),
        .overflow_o       (overflow),
        .miss_count_o     (miss_count),
        .sleep_o          (sleep)
    );

    typedef struct {
        int          l1;
        int          l0;
        logic [5:0]  ca;
        logic [5:0]  cd;
        logic [15:0] a;
        logic        rw;
        logic [7:0]  d;
        int          ea;
        int          ed;
        logic [7:0]  edo;
        bit          push;
        logic [7:0]  emiss;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One Phi1 phase of l1 clocks followed by one Phi0 phase of l0 clocks.
    task automatic bus_cycle(input int l1, input int l0, input logic [5:0] ca, input logic [5:0] cd,
                             input logic [15:0] a, input logic rw, input logic [7:0] d,
                             input bit rdy_at_data,
                             output int a_idx, output int d_idx, output int a_n, output int d_n,
                             output logic v_at_d);
        a_idx = -1; d_idx = -1; a_n = 0; d_n = 0; v_at_d = 1'b0;
        @(negedge clk);
        phi1 = 1'b1; cfg_addr = ca; cfg_data = cd; a2_a = a; a2_rw_n = rw; a2_d = d;
        for (int i = 0; i < l1; i++) begin
            @(posedge clk); #1;
            if (addr_strobe) begin
                a_n++;
                if (a_idx < 0) a_idx = i;
            end
            if (data_strobe) d_n++;
        end
        @(negedge clk);
        phi1 = 1'b0;
        for (int i = 0; i < l0; i++) begin
            @(posedge clk); #1;
            if (data_strobe) begin
                d_n++;
                if (d_idx < 0) begin
                    d_idx  = i;
                    v_at_d = rd_valid;
                end
            end
            if (addr_strobe) a_n++;
            rd_ready = (rdy_at_data && i == int'(cd)) ? 1'b1 : 1'b0;
        end
        rd_ready = 1'b0;
    endtask

    task automatic pop_check(input string nm, input logic [24:0] exp);
        chk({nm, "_valid"}, {31'd0, rd_valid}, 32'd1);
        chk({nm, "_data"}, {7'd0, rd_data}, {7'd0, exp});
        @(negedge clk); rd_ready = 1'b1;
        @(posedge clk); #1; rd_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk); clr = 1'b1;
        @(posedge clk); #1; clr = 1'b0;
    endtask

    int         ai, di, an, dn;
    logic       vd;
    logic [24:0] exp_e;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{26, 26, 6'd18, 6'd5,  16'hC0A5, 1'b0, 8'h3C, 19,  6, 8'h3C, 1'b1, 8'd0};
        tbl[1] = '{26, 26, 6'd18, 6'd5,  16'h1234, 1'b1, 8'h77, 19,  6, 8'h3C, 1'b1, 8'd0};
        tbl[2] = '{26, 26, 6'd30, 6'd5,  16'h5A5A, 1'b0, 8'h55, -1,  6, 8'h3C, 1'b0, 8'd1};
        tbl[3] = '{26, 26, 6'd18, 6'd5,  16'hBEEF, 1'b0, 8'hA5, 19,  6, 8'hA5, 1'b1, 8'd1};
        tbl[4] = '{26, 26, 6'd18, 6'd30, 16'h0102, 1'b0, 8'h99, 19, -1, 8'hA5, 1'b0, 8'd1};
        tbl[5] = '{26, 26, 6'd18, 6'd5,  16'h4321, 1'b1, 8'h11, 19,  6, 8'hA5, 1'b1, 8'd2};
        tbl[6] = '{8,  12, 6'd3,  6'd10, 16'h00FF, 1'b0, 8'h5A,  4, 11, 8'h5A, 1'b1, 8'd2};
        tbl[7] = '{8,  12, 6'd6,  6'd10, 16'hFFFF, 1'b0, 8'hFF,  7, 11, 8'hFF, 1'b1, 8'd2};
        tbl[8] = '{8,  12, 6'd7,  6'd10, 16'h0000, 1'b1, 8'h00, -1, 11, 8'h00, 1'b0, 8'd3};

        rst_n = 1'b0; phi1 = 1'b0; a2_a = '0; a2_d = '0; a2_rw_n = 1'b1;
        cfg_addr = 6'd18; cfg_data = 6'd5; clr = 1'b0; rd_ready = 1'b0;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk("rst_valid",    {31'd0, rd_valid},    32'd0);
        chk("rst_sleep",    {31'd0, sleep},       32'd1);
        chk("rst_addr",     {16'd0, addr},        32'd0);
        chk("rst_rw_n",     {31'd0, rw_n},        32'd1);
        chk("rst_data",     {24'd0, data},        32'd0);
        chk("rst_astb",     {31'd0, addr_strobe}, 32'd0);
        chk("rst_dstb",     {31'd0, data_strobe}, 32'd0);
        chk("rst_ovf",      {31'd0, overflow},    32'd0);
        chk("rst_miss",     {24'd0, miss_count},  32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Warm-up read cycle; sleep must drop right after the first edge
        @(negedge clk);
        phi1 = 1'b1; a2_a = 16'h0ABC; a2_rw_n = 1'b1; a2_d = 8'h5D;
        @(posedge clk); #1;
        chk("sleep_first_edge", {31'd0, sleep}, 32'd0);
        for (int i = 1; i < 26; i++) @(posedge clk);
        @(negedge clk); phi1 = 1'b0;
        for (int i = 0; i < 26; i++) @(posedge clk);
        #1;
        chk("warm_data_hold", {24'd0, data}, 32'd0);
        pop_check("warm_entry", {1'b1, 16'h0ABC, 8'h5D});
        chk("warm_empty", {31'd0, rd_valid}, 32'd0);
        pulse_clr();
        chk("warm_clr_miss", {24'd0, miss_count}, 32'd0);

        // Table-driven bus cycles
        for (int k = 0; k < 9; k++) begin
            bus_cycle(tbl[k].l1, tbl[k].l0, tbl[k].ca, tbl[k].cd, tbl[k].a, tbl[k].rw, tbl[k].d,
                      1'b0, ai, di, an, dn, vd);
            chk($sformatf("v%0d_aidx", k), ai, tbl[k].ea);
            chk($sformatf("v%0d_acnt", k), an, (tbl[k].ea >= 0) ? 1 : 0);
            chk($sformatf("v%0d_didx", k), di, tbl[k].ed);
            chk($sformatf("v%0d_dcnt", k), dn, (tbl[k].ed >= 0) ? 1 : 0);
            chk($sformatf("v%0d_data", k), {24'd0, data}, {24'd0, tbl[k].edo});
            chk($sformatf("v%0d_miss", k), {24'd0, miss_count}, {24'd0, tbl[k].emiss});
            if (tbl[k].ea >= 0) begin
                chk($sformatf("v%0d_addr", k), {16'd0, addr}, {16'd0, tbl[k].a});
                chk($sformatf("v%0d_rw", k), {31'd0, rw_n}, {31'd0, tbl[k].rw});
            end
            if (tbl[k].ed >= 0)
                chk($sformatf("v%0d_valid_at_dstb", k), {31'd0, vd}, {31'd0, tbl[k].push});
            if (tbl[k].push)
                pop_check($sformatf("v%0d_entry", k), {tbl[k].rw, tbl[k].a, tbl[k].d});
            chk($sformatf("v%0d_empty", k), {31'd0, rd_valid}, 32'd0);
        end

        // Overflow: five pushes into a four-entry FIFO with the reader stalled
        pulse_clr();
        for (int k = 0; k < 5; k++) begin
            bus_cycle(26, 26, 6'd18, 6'd5, 16'h1000 + 16'(k), 1'b0, 8'h10 + 8'(k), 1'b0,
                      ai, di, an, dn, vd);
            if (k == 3) chk("ovf_before", {31'd0, overflow}, 32'd0);
        end
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        pulse_clr();
        chk("ovf_clr", {31'd0, overflow}, 32'd0);
        bus_cycle(26, 26, 6'd18, 6'd5, 16'h2000, 1'b0, 8'h66, 1'b1, ai, di, an, dn, vd);
        chk("ovf_push_pop_full", {31'd0, overflow}, 32'd0);
        for (int k = 1; k < 4; k++) begin
            exp_e = {1'b0, 16'h1000 + 16'(k), 8'h10 + 8'(k)};
            pop_check($sformatf("ovf_drain%0d", k), exp_e);
        end
        pop_check("ovf_drain_new", {1'b0, 16'h2000, 8'h66});
        chk("ovf_drained", {31'd0, rd_valid}, 32'd0);
        chk("ovf_miss", {24'd0, miss_count}, 32'd0);

        // Sleep and reset with two entries queued and a miss recorded
        bus_cycle(26, 26, 6'd18, 6'd5, 16'h3001, 1'b0, 8'h31, 1'b0, ai, di, an, dn, vd);
        bus_cycle(8, 12, 6'd30, 6'd10, 16'h3002, 1'b0, 8'h32, 1'b0, ai, di, an, dn, vd);
        bus_cycle(26, 26, 6'd18, 6'd5, 16'h3003, 1'b0, 8'h33, 1'b0, ai, di, an, dn, vd);
        chk("slp_miss_pre", {24'd0, miss_count}, 32'd1);
        @(negedge clk); phi1 = 1'b1;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk); #1;
            if (i == 62) chk("slp_cnt62", {31'd0, sleep}, 32'd0);
            if (i == 63) chk("slp_cnt63", {31'd0, sleep}, 32'd1);
        end
        chk("slp_cnt_sat", {31'd0, sleep}, 32'd1);
        @(negedge clk); phi1 = 1'b0;
        for (int i = 0; i < 3; i++) @(posedge clk);
        #1;
        chk("slp_valid_pre", {31'd0, rd_valid}, 32'd1);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_valid", {31'd0, rd_valid},   32'd0);
        chk("midrst_miss",  {24'd0, miss_count}, 32'd0);
        chk("midrst_sleep", {31'd0, sleep},      32'd1);
        chk("midrst_data",  {24'd0, data},       32'd0);
        chk("midrst_rw_n",  {31'd0, rw_n},       32'd1);
        @(negedge clk); rst_n = 1'b1;

        // Saturation: 300 consecutive phases that never reach a sample point
        cfg_addr = 6'd30; cfg_data = 6'd30;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk); phi1 = ~phi1;
            @(posedge clk); @(posedge clk);
        end
        #1;
        chk("sat_miss", {24'd0, miss_count}, 32'd255);
        @(negedge clk); phi1 = ~phi1; clr = 1'b1;
        @(posedge clk); #1; clr = 1'b0;
        chk("clr_vs_miss", {24'd0, miss_count}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
